// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - FSM state encoding and width helper for mem_read_sequencer
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Address and data share one width: twice the memory size parameter.
  function automatic int addr_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mem_seq_addr_gen.sv
// rtl/mem_seq_addr_gen.sv - sweep address register with wrap-around increment and end flag
module mem_seq_addr_gen #(
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_start_addr,
  input  logic [AW-1:0] i_end_addr,
  input  logic          i_inc,
  output logic [AW-1:0] o_cur,
  output logic [AW-1:0] o_next,
  output logic          o_at_end
);

  logic [AW-1:0] r_cur;
  logic [AW-1:0] r_end;
  logic [AW-1:0] w_next;

  // Natural overflow of the AW-bit add gives the wrap from all-ones to zero.
  assign w_next = r_cur + AW'(1);

  // Load the sweep bounds on an accepted start, step on each consumer handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur <= '0;
      r_end <= '0;
    end else if (i_load) begin
      r_cur <= i_start_addr;
      r_end <= i_end_addr;
    end else if (i_inc) begin
      r_cur <= w_next;
    end
  end

  assign o_cur    = r_cur;
  assign o_next   = w_next;
  assign o_at_end = (r_cur == r_end);

endmodule

// File: rtl/mem_read_sequencer.sv
// rtl/mem_read_sequencer.sv - address-sweeping read master for memory_code; optional CHECKSUM_EN adds an XOR checksum port
module mem_read_sequencer
  import mem_seq_pkg::*;
#(
  parameter int N      = 2,
  parameter int RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2*N-1:0]   i_start_addr,
  input  logic [2*N-1:0]   i_end_addr,
  output logic             o_busy,
  output logic             o_done,
  output logic [2*N-1:0]   o_mem_address,
  output logic             o_mem_en,
  output logic             o_mem_read_en,
  input  logic [2*N-1:0]   i_mem_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [2*N-1:0]   o_out_addr,
  output logic [2*N-1:0]   o_out_data
`ifdef CHECKSUM_EN
  ,
  output logic [2*N-1:0]   o_checksum
`endif
);

  localparam int AW = addr_w(N);
  localparam int CW = $clog2(RD_LAT + 1);

  seq_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_mem_address;
  logic          r_mem_en;
  logic          r_out_valid;
  logic [AW-1:0] r_out_addr;
  logic [AW-1:0] r_out_data;

  logic          w_load;
  logic          w_last_wait;
  logic          w_capture;
  logic          w_handshake;
  logic [AW-1:0] w_cur;
  logic [AW-1:0] w_cur_next;
  logic          w_at_end;

  assign w_load      = (r_state == IDLE) && i_start;
  assign w_last_wait = (r_cnt == CW'(RD_LAT - 1));
  assign w_capture   = (r_state == ISSUE) && w_last_wait;
  assign w_handshake = (r_state == OUT) && i_out_ready;

  mem_seq_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_start_addr(i_start_addr),
    .i_end_addr  (i_end_addr),
    .i_inc       (w_handshake && !w_at_end),
    .o_cur       (w_cur),
    .o_next      (w_cur_next),
    .o_at_end    (w_at_end)
  );

  // Sweep FSM; every memory and consumer output is a register written here
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_address <= '0;
      r_mem_en      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_addr    <= '0;
      r_out_data    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            // The address generator loads on this same edge, so drive the
            // memory straight from the start input.
            r_state       <= ISSUE;
            r_cnt         <= '0;
            r_busy        <= 1'b1;
            r_mem_en      <= 1'b1;
            r_mem_address <= i_start_addr;
          end
        end
        ISSUE: begin
          if (w_last_wait) begin
            r_state       <= OUT;
            r_mem_en      <= 1'b0;
            r_mem_address <= '0;
            r_out_valid   <= 1'b1;
            r_out_addr    <= w_cur;
            r_out_data    <= i_mem_data;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (w_at_end) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state       <= ISSUE;
              r_cnt         <= '0;
              r_mem_en      <= 1'b1;
              r_mem_address <= w_cur_next;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_mem_address = r_mem_address;
  assign o_mem_en      = r_mem_en;
  assign o_mem_read_en = r_mem_en;
  assign o_out_valid   = r_out_valid;
  assign o_out_addr    = r_out_addr;
  assign o_out_data    = r_out_data;

`ifdef CHECKSUM_EN
  logic [AW-1:0] r_checksum;

  // Running XOR of the sweep's words; cleared on start, held after DONE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_checksum <= '0;
    end else if (w_load) begin
      r_checksum <= '0;
    end else if (w_capture) begin
      r_checksum <= r_checksum ^ i_mem_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule
